// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin packet-locking arbiter for a FIFO write port; FIFO_ARB_STATS_EN adds per-requester packet counters
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
`ifdef FIFO_ARB_STATS_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wen,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  input  logic                          fifo_full,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          busy
`ifdef FIFO_ARB_STATS_EN
  , output logic [NUM_REQ*CNT_WIDTH-1:0] grant_cnt
`endif
);
  typedef enum logic {IDLE, LOCKED} state_t;
  localparam logic [ID_WIDTH:0] NR = (ID_WIDTH+1)'(NUM_REQ);
  state_t state_q, state_d;
  logic [ID_WIDTH-1:0] owner_q, owner_d, rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0] win, idx, sel, nxt;
  logic [ID_WIDTH:0] sum;
  logic found, has_sel, xfer;
  // round-robin search from rr_ptr; descending loop lets the closest valid requester win
  always_comb begin
    win = '0;
    found = 1'b0;
    sum = '0;
    idx = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr_q} + (ID_WIDTH+1)'(k);
      idx = ID_WIDTH'(sum >= NR ? sum - NR : sum);
      if (req_valid[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  // selection, handshake outputs and next state; the lock pins selection to the owner
  always_comb begin
    sel = state_q == LOCKED ? owner_q : win;
    has_sel = state_q == LOCKED || found;
    xfer = has_sel && req_valid[sel] && !fifo_full;
    nxt = sel == ID_WIDTH'(NUM_REQ-1) ? '0 : sel + 1'b1;
    state_d = state_q;
    owner_d = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (xfer && req_last[sel]) begin
      state_d = IDLE;
      rr_ptr_d = nxt;
    end else if (xfer && state_q == IDLE) begin
      state_d = LOCKED;
      owner_d = sel;
    end
    req_ready = xfer ? NUM_REQ'(1) << sel : '0;
    fifo_wen = xfer;
    fifo_wdata = has_sel ? req_data[sel*DATA_WIDTH +: DATA_WIDTH] : '0;
    grant_id = has_sel ? sel : '0;
    busy = state_q == LOCKED;
  end
  // state, owner and round-robin pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
`ifdef FIFO_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_q [NUM_REQ];
  // saturating completed-packet counters, bumped when a last beat transfers
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '{default: '0};
    else if (xfer && req_last[sel] && cnt_q[sel] != '1) cnt_q[sel] <= cnt_q[sel] + 1'b1;
  end
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign grant_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed vector table plus randomized run against a packet-level reference model
module tb_fifo_wr_arbiter;
  localparam int N = 4, DW = 8, IW = 2;
`ifdef FIFO_ARB_STATS_EN
  localparam int CW = 2;
  logic [N*CW-1:0] grant_cnt;
`endif
  typedef struct {
    logic r; logic [3:0] v; logic [31:0] d; logic [3:0] l; logic f;
    logic wen; logic [7:0] wd; logic [1:0] gid; logic busy; logic [3:0] rdy;
  } vec_t;
  logic clk = 0, rst = 1, fifo_full = 0;
  logic [N-1:0] req_valid = 0, req_last = 0, req_ready;
  logic [N*DW-1:0] req_data = 0;
  logic fifo_wen, busy;
  logic [DW-1:0] fifo_wdata;
  logic [IW-1:0] grant_id;
  int n_cmp = 0, n_bad = 0;
  bit m_locked = 0;
  int m_owner = 0, m_ptr = 0;
  int m_cnt [N] = '{default: 0};
  vec_t tbl[$];
  vec_t none;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)
`ifdef FIFO_ARB_STATS_EN
    , .CNT_WIDTH(CW)
`endif
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full),
    .grant_id(grant_id), .busy(busy)
`ifdef FIFO_ARB_STATS_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                     input logic f, input logic wen, input logic [7:0] wd, input logic [1:0] gid,
                     input logic b, input logic [3:0] rdy);
    tbl.push_back('{r, v, d, l, f, wen, wd, gid, b, rdy});
  endtask

  // one cycle: check outputs mid-cycle, advance the reference model, cross the clock edge
  task automatic step(input bit use_tbl, input vec_t v);
    int sel;
    bit has, xfer;
    logic [7:0] e_wd;
    #2;
    sel = 0;
    has = 0;
    if (m_locked) begin
      sel = m_owner;
      has = 1;
    end else
      for (int k = 0; k < N; k++)
        if (!has && req_valid[(m_ptr + k) % N]) begin
          sel = (m_ptr + k) % N;
          has = 1;
        end
    xfer = has && req_valid[sel] && !fifo_full;
    e_wd = has ? req_data[sel*DW +: DW] : 8'h0;
    if (use_tbl) begin
      chk("wen", fifo_wen, v.wen);
      chk("wdata", fifo_wdata, v.wd);
      chk("grant_id", grant_id, v.gid);
      chk("busy", busy, v.busy);
      chk("ready", req_ready, v.rdy);
    end else begin
      chk("rnd_wen", fifo_wen, xfer);
      chk("rnd_wdata", fifo_wdata, e_wd);
      chk("rnd_grant_id", grant_id, has ? sel : 0);
      chk("rnd_busy", busy, m_locked);
      chk("rnd_ready", req_ready, xfer ? (4'b1 << sel) : 4'b0);
    end
`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk($sformatf("grant_cnt%0d", i), grant_cnt[i*CW +: CW], m_cnt[i]);
`endif
    if (rst) begin
      m_locked = 0;
      m_owner = 0;
      m_ptr = 0;
      m_cnt = '{default: 0};
    end else if (xfer && req_last[sel]) begin
      m_locked = 0;
      m_ptr = (sel + 1) % N;
      if (m_cnt[sel] < (1 << CW_OR_16()) - 1) m_cnt[sel]++;
    end else if (xfer && !m_locked) begin
      m_locked = 1;
      m_owner = sel;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int CW_OR_16();
`ifdef FIFO_ARB_STATS_EN
    return CW;
`else
    return 16;
`endif
  endfunction

  initial begin
    none = '{default: '0};
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    add(0, 4'b0000, 32'h0, 4'b0000, 0, 0, 8'h00, 0, 0, 4'b0000);
    add(0, 4'b0001, 32'h11, 4'b0000, 0, 1, 8'h11, 0, 0, 4'b0001);
    add(0, 4'b0001, 32'h22, 4'b0000, 0, 1, 8'h22, 0, 1, 4'b0001);
    add(0, 4'b0001, 32'h33, 4'b0001, 0, 1, 8'h33, 0, 1, 4'b0001);
    add(0, 4'b0011, 32'h0000A1A0, 4'b0011, 0, 1, 8'hA1, 1, 0, 4'b0010);
    add(1, 4'b0000, 32'h0, 4'b0000, 0, 0, 8'h00, 0, 0, 4'b0000);
    for (int i = 0; i < 6; i++)
      add(0, 4'hF, 32'h33221100, 4'hF, 0, 1, 8'((i % 4) * 8'h11), 2'(i % 4), 0, 4'(1 << (i % 4)));
    add(0, 4'b0010, 32'h0000B100, 4'b0000, 0, 1, 8'hB1, 1, 0, 4'b0010);
    add(0, 4'b0111, 32'h00C2B2C0, 4'b0101, 0, 1, 8'hB2, 1, 1, 4'b0010);
    add(0, 4'b0111, 32'h00C2B3C0, 4'b0111, 0, 1, 8'hB3, 1, 1, 4'b0010);
    add(0, 4'b0101, 32'h00C200C0, 4'b0101, 0, 1, 8'hC2, 2, 0, 4'b0100);
    add(0, 4'b0001, 32'h000000C0, 4'b0001, 0, 1, 8'hC0, 0, 0, 4'b0001);
    add(0, 4'b1000, 32'hD1000000, 4'b0000, 0, 1, 8'hD1, 3, 0, 4'b1000);
    add(0, 4'b1000, 32'hD2000000, 4'b0000, 1, 0, 8'hD2, 3, 1, 4'b0000);
    add(0, 4'b1000, 32'hD2000000, 4'b0000, 1, 0, 8'hD2, 3, 1, 4'b0000);
    add(0, 4'b0000, 32'hD2000000, 4'b0000, 0, 0, 8'hD2, 3, 1, 4'b0000);
    add(0, 4'b1000, 32'hD2000000, 4'b0000, 0, 1, 8'hD2, 3, 1, 4'b1000);
    add(0, 4'b1000, 32'hD3000000, 4'b1000, 0, 1, 8'hD3, 3, 1, 4'b1000);
    add(0, 4'b0100, 32'h00E00000, 4'b0000, 1, 0, 8'hE0, 2, 0, 4'b0000);
    add(0, 4'b0100, 32'h00E10000, 4'b0000, 0, 1, 8'hE1, 2, 0, 4'b0100);
    add(1, 4'b0100, 32'h00E20000, 4'b0000, 0, 1, 8'hE2, 2, 1, 4'b0100);
    add(0, 4'b0101, 32'h00E200F0, 4'b0101, 0, 1, 8'hF0, 0, 0, 4'b0001);
    foreach (tbl[i]) begin
      rst = tbl[i].r;
      req_valid = tbl[i].v;
      req_data = tbl[i].d;
      req_last = tbl[i].l;
      fifo_full = tbl[i].f;
      step(1, tbl[i]);
    end
`ifdef FIFO_ARB_STATS_EN
    rst = 1;
    req_valid = 0;
    step(0, none);
    rst = 0;
    req_data = 32'h00550000;
    for (int p = 0; p < 5; p++) begin
      req_valid = 4'b0100;
      req_last = 4'b0100;
      step(0, none);
    end
    req_valid = 0;
    #1;
    chk("sat_cnt2", grant_cnt[2*CW +: CW], 2'd3);
    chk("sat_cnt0", grant_cnt[0 +: CW], 2'd0);
    chk("sat_cnt1", grant_cnt[CW +: CW], 2'd0);
    chk("sat_cnt3", grant_cnt[3*CW +: CW], 2'd0);
`endif
    for (int c = 0; c < 3000; c++) begin
      rst = $urandom_range(0, 59) == 0;
      req_valid = 4'($urandom);
      for (int i = 0; i < N; i++) req_last[i] = $urandom_range(0, 2) == 0;
      fifo_full = $urandom_range(0, 3) == 0;
      req_data = $urandom;
      step(0, none);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
